// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN (typematic repeat filter in the top).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
    localparam logic [7:0] PS2_ACK      = 8'hFA;
    localparam logic [7:0] PS2_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
    localparam logic [7:0] PS2_OVR0     = 8'h00;
    localparam logic [7:0] PS2_OVR1     = 8'hFF;

    // Bytes that follow E1 before the Pause key is complete.
    localparam logic [2:0] PAUSE_TAIL_LEN = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status / overrun bytes that never become key events.
    function automatic logic is_ignored(input logic [7:0] b);
        logic r;
        case (b)
            PS2_OVR0, PS2_OVR1, PS2_BAT_OK, PS2_ACK,
            PS2_RESEND, PS2_ECHO, PS2_BAT_FAIL: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous key-event FIFO with a registered head word and registered status.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  ps2_evt_t                 push_data_i,
    input  logic                     pop_i,
    output ps2_evt_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ps2_evt_t          mem_q [DEPTH];
    ps2_evt_t          head_q, head_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, full_q;
    logic              do_push_s, do_pop_s;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop_s  = pop_i && valid_q;
    assign do_push_s = push_i && (!full_q || do_pop_s);

    // Next pointers, occupancy and head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1'b1);
        end else if (!do_push_s && do_pop_s) begin
            count_d = count_q - CW'(1'b1);
        end else begin
            count_d = count_q;
        end
        // Head tracks the oldest entry; a lone entry being replaced is bypassed from the push.
        if (!valid_q) begin
            if (do_push_s) begin
                head_d = push_data_i;
            end else begin
                head_d = head_q;
            end
        end else if (do_pop_s) begin
            if (count_q == CW'(1'b1)) begin
                if (do_push_s) begin
                    head_d = push_data_i;
                end else begin
                    head_d = head_q;
                end
            end else begin
                head_d = mem_q[rd_ptr_q + AW'(1'b1)];
            end
        end else begin
            head_d = head_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
            full_q   <= (count_d == CW'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = !valid_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefixes into single key events
// and queues them for a valid/ready consumer.
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN suppresses typematic make repeats.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_err,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_brk,
    output logic                          evt_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e   state_q, state_d;
    logic [2:0]   pause_cnt_q, pause_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic         overflow_q, frame_err_q;
    logic         dec_push_s, suppress_s, push_s, pop_s, fifo_full_s, fifo_empty_s;
    ps2_evt_t     dec_evt_s, head_s;

    // Prefix parser: next state and the event (if any) produced by this byte.
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        dec_push_s  = 1'b0;
        dec_evt_s   = '{ext: 1'b0, brk: 1'b0, code: byte_data};
        if (byte_valid) begin
            if (byte_err) begin
                state_d     = ST_IDLE;
                pause_cnt_d = 3'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (byte_data == PS2_EXT) begin
                            state_d = ST_EXT;
                        end else if (byte_data == PS2_BRK) begin
                            state_d = ST_BRK;
                        end else if (byte_data == PS2_PAUSE) begin
                            state_d     = ST_PAUSE;
                            pause_cnt_d = 3'd0;
                        end else if (is_ignored(byte_data)) begin
                            state_d = ST_IDLE;
                        end else begin
                            dec_push_s = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (byte_data == PS2_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            dec_push_s    = 1'b1;
                            dec_evt_s.ext = 1'b1;
                            state_d       = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        dec_push_s    = 1'b1;
                        dec_evt_s.brk = 1'b1;
                        state_d       = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        dec_push_s    = 1'b1;
                        dec_evt_s.ext = 1'b1;
                        dec_evt_s.brk = 1'b1;
                        state_d       = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        if (pause_cnt_q == PAUSE_TAIL_LEN - 3'd1) begin
                            dec_push_s     = 1'b1;
                            dec_evt_s.ext  = 1'b1;
                            dec_evt_s.code = PS2_PAUSE;
                            state_d        = ST_IDLE;
                            pause_cnt_d    = 3'd0;
                        end else begin
                            pause_cnt_d = pause_cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_d     = ST_IDLE;
                        pause_cnt_d = 3'd0;
                    end
                endcase
            end
        end else if (state_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            pause_cnt_d = 3'd0;
        end else begin
            state_d = state_q;
        end
        // Idle timer only runs while a prefix is pending and the line is quiet.
        if (byte_valid || state_q == ST_IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1'b1);
        end
    end

    // Parser state registers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pause_cnt_q <= 3'd0;
            timer_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            timer_q     <= timer_d;
            overflow_q  <= overflow_q | (push_s && fifo_full_s && !pop_s);
            frame_err_q <= frame_err_q | (byte_valid && byte_err);
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_ext_q, held_q;
    logic [7:0] last_code_q;
    logic       match_s;

    assign match_s    = (dec_evt_s.ext == last_ext_q) && (dec_evt_s.code == last_code_q);
    assign suppress_s = dec_push_s && !dec_evt_s.brk && held_q && match_s;

    // Remember the last make; a matching break releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ext_q  <= 1'b0;
            last_code_q <= 8'h00;
            held_q      <= 1'b0;
        end else if (dec_push_s && !dec_evt_s.brk) begin
            last_ext_q  <= dec_evt_s.ext;
            last_code_q <= dec_evt_s.code;
            held_q      <= 1'b1;
        end else if (dec_push_s && match_s) begin
            held_q      <= 1'b0;
        end else begin
            held_q      <= held_q;
        end
    end
`else
    assign suppress_s = 1'b0;
`endif

    assign push_s = dec_push_s && !suppress_s;
    assign pop_s  = evt_ready && !fifo_empty_s;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push_s),
        .push_data_i (dec_evt_s),
        .pop_i       (evt_ready),
        .head_o      (head_s),
        .count_o     (fifo_count),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign evt_valid = !fifo_empty_s;
    assign evt_code  = head_s.code;
    assign evt_brk   = head_s.brk;
    assign evt_ext   = head_s.ext;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: event-queue model plus directed sequences.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TOUT  = 40;

    logic       clk, rst, byte_valid, byte_err, evt_valid, evt_ready;
    logic [7:0] byte_data, evt_code;
    logic       evt_brk, evt_ext, overflow, frame_err;
    logic [$clog2(DEPTH):0] fifo_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_err(byte_err), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_brk(evt_brk), .evt_ext(evt_ext),
        .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] m_q [$];
    bit   m_ovf, m_ferr, p_ext, p_brk, held, have, popit;
    int   pause_left, gap;
    logic [8:0] last_make;
    logic [9:0] ev;

    function automatic bit ignored(input logic [7:0] b);
        return b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_ferr = 0; p_ext = 0; p_brk = 0; pause_left = 0;
            gap = 0; held = 0; last_make = '0;
        end else begin
            popit = evt_ready && (m_q.size() != 0);
            have = 0;
            ev = '0;
            if (byte_valid) begin
                if (gap >= TOUT) begin p_ext = 0; p_brk = 0; pause_left = 0; end
                gap = 0;
                if (byte_err) begin
                    m_ferr = 1; p_ext = 0; p_brk = 0; pause_left = 0;
                end else if (pause_left > 0) begin
                    pause_left--;
                    if (pause_left == 0) begin have = 1; ev = {2'b10, 8'hE1}; end
                end else if (p_brk) begin
                    have = 1; ev = {p_ext, 1'b1, byte_data}; p_ext = 0; p_brk = 0;
                end else if (p_ext) begin
                    if (byte_data == 8'hF0) p_brk = 1;
                    else begin have = 1; ev = {2'b10, byte_data}; p_ext = 0; end
                end else if (byte_data == 8'hE0) p_ext = 1;
                else if (byte_data == 8'hF0) p_brk = 1;
                else if (byte_data == 8'hE1) pause_left = 7;
                else if (!ignored(byte_data)) begin have = 1; ev = {2'b00, byte_data}; end
            end else begin
                gap++;
            end
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (have) begin
                if (!ev[8]) begin
                    if (held && {ev[9], ev[7:0]} == last_make) have = 0;
                    else begin last_make = {ev[9], ev[7:0]}; held = 1; end
                end else if ({ev[9], ev[7:0]} == last_make) begin
                    held = 0;
                end
            end
`endif
            if (popit) void'(m_q.pop_front());
            if (have) begin
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else m_ovf = 1;
            end
        end
    end

    // ---------------- per-cycle compare and pop recorder ----------------
    logic [9:0] popped [$];
    logic [9:0] exp_q  [$];
    logic [9:0] m_head;

    always @(negedge clk) begin
        #1;
        if (!rst && evt_valid && evt_ready) popped.push_back({evt_ext, evt_brk, evt_code});
        if (chk_en) begin
            m_head = (m_q.size() != 0) ? m_q[0] : 10'h000;
            check("cycle",
                  {16'h0, evt_valid, 4'(fifo_count), overflow, frame_err,
                   (evt_valid ? {evt_ext, evt_brk, evt_code} : 10'h000)},
                  {16'h0, (m_q.size() != 0), 4'(m_q.size()), m_ovf, m_ferr, m_head});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b, input logic e = 1'b0);
        byte_valid = 1'b1; byte_data = b; byte_err = e;
        @(negedge clk);
        byte_valid = 1'b0; byte_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_and_check(input string name);
        evt_ready = 1'b1;
        idle(DEPTH + 4);
        check({name, "_n"}, popped.size(), exp_q.size());
        for (int i = 0; i < popped.size() && i < exp_q.size(); i++)
            check(name, popped[i], exp_q[i]);
        popped.delete();
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; byte_err = 1'b0; evt_ready = 1'b0;
        idle(3);
        check("rst_valid", evt_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_flags", {overflow, frame_err}, 0);
        rst = 1'b0;
        chk_en = 1;
        idle(2);

        // Plain make/break and one-cycle latency.
        check("pre_valid", evt_valid, 0);
        send(8'h1C);
        check("lat_valid", evt_valid, 1);
        check("lat_evt", {evt_ext, evt_brk, evt_code}, 10'h01C);
        send(8'hF0); send(8'h1C);
        check("mb_count", fifo_count, 2);
        exp_q = '{10'h01C, 10'h11C};
        drain_and_check("makebrk");

        // Extended keys with ignored bytes in between.
        send(8'hE0); send(8'h75); send(8'hAA); send(8'hFA); send(8'h00);
        send(8'hE0); send(8'hF0); send(8'h75);
        exp_q = '{10'h275, 10'h375};
        drain_and_check("ext");

        // Pause sequence then a normal key.
        foreach (exp_q[i]) ;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        exp_q = '{10'h2E1, 10'h01C};
        drain_and_check("pause");

        // Overflow with consumer stalled, then push on full with same-cycle pop.
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
        check("ovf_count", fifo_count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", {evt_ext, evt_brk, evt_code}, 10'h015);
        evt_ready = 1'b1;
        send(8'h2A);
        evt_ready = 1'b0;
        check("fullpp_count", fifo_count, 8);
        check("fullpp_head", evt_code, 8'h16);
        exp_q = '{10'h015, 10'h016, 10'h017, 10'h018, 10'h019,
                  10'h01A, 10'h01B, 10'h01C, 10'h02A};
        drain_and_check("ovf");

        // Errored byte drops a pending prefix.
        send(8'hE0); send(8'h1C, 1'b1); send(8'h1C);
        check("ferr", frame_err, 1);
        exp_q = '{10'h01C};
        drain_and_check("err");

        // Timeout discards a stale prefix; a short gap keeps it.
        send(8'hE0); idle(TOUT + 5); send(8'h75);
        send(8'hE0); idle(TOUT - 5); send(8'h75);
        exp_q = '{10'h075, 10'h275};
        drain_and_check("tout");

        // Reset mid-sequence flushes FIFO and prefix.
        evt_ready = 1'b0;
        send(8'h1C); send(8'hE0);
        rst = 1'b1; idle(2); rst = 1'b0;
        check("mrst_count", fifo_count, 0);
        check("mrst_flags", {overflow, frame_err}, 0);
        send(8'h75);
        exp_q = '{10'h075};
        drain_and_check("midrst");

        // Typematic repeats.
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_q = '{10'h01C, 10'h11C, 10'h01C};
`else
        exp_q = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        drain_and_check("typematic");

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
